// File: rtl/row_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : row_sched_pkg
//  Description : Shared types, defaults and helpers for the row scan
//                scheduler block.
//  Revision    : 1.0  initial release
// ============================================================================
package row_sched_pkg;

    localparam int unsigned DWELL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Requested row count saturated to the physical row count.
    function automatic int unsigned clamp_rows(input int unsigned requested,
                                               input int unsigned limit);
        return (requested > limit) ? limit : requested;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_scan_scheduler_if
//  Description : Control, configuration and row handshake bundle of the row
//                scan scheduler. master = scheduler, slave = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface row_scan_scheduler_if #(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned PTR_BITS = $clog2(NUM_ROWS),
    parameter int unsigned DWELL_W  = row_sched_pkg::DWELL_W_DEFAULT
);

    logic                start;
    logic                abort;
    logic [PTR_BITS-1:0] cfg_first_row;
    logic [PTR_BITS:0]   cfg_num_rows;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic                row_valid;
    logic                row_ready;
    logic [PTR_BITS-1:0] row_ptr;
    logic                row_last;
    logic                busy;
    logic                done;

    modport master (
        input  start, abort, cfg_first_row, cfg_num_rows, cfg_dwell, row_ready,
        output row_valid, row_ptr, row_last, busy, done
    );

    modport slave (
        output start, abort, cfg_first_row, cfg_num_rows, cfg_dwell, row_ready,
        input  row_valid, row_ptr, row_last, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/row_ptr_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : row_ptr_wrap_counter
//  Description : Row pointer with synchronous load and increment that wraps
//                modulo NUM_ROWS (NUM_ROWS need not be a power of two).
//  Revision    : 1.0  initial release
// ============================================================================
module row_ptr_wrap_counter #(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned PTR_BITS = $clog2(NUM_ROWS)
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                load,
    input  wire logic [PTR_BITS-1:0] load_value,
    input  wire logic                incr,
    output logic      [PTR_BITS-1:0] count
);

    localparam logic [PTR_BITS-1:0] c_last    = PTR_BITS'(NUM_ROWS - 1);
    localparam logic [PTR_BITS-1:0] c_ptr_one = PTR_BITS'(1);

    logic [PTR_BITS-1:0] w_load_value;

    // An out-of-range load value can only exist when the pointer field has
    // spare codes; fold it back into range so the wrap compare stays valid.
    if ((1 << PTR_BITS) == NUM_ROWS) begin : g_pow2_load
        assign w_load_value = load_value;
    end else begin : g_wrap_load
        localparam logic [PTR_BITS-1:0] c_rows = PTR_BITS'(NUM_ROWS);
        assign w_load_value = (load_value > c_last) ? (load_value - c_rows) : load_value;
    end

    // Load has priority over increment; increment wraps after the last row.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= w_load_value;
        end else if (incr) begin
            count <= (count == c_last) ? '0 : (count + c_ptr_one);
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : row_scan_scheduler
//  Description : Walks a configurable window of buffer rows, offering one row
//                index per valid/ready handshake with an optional idle dwell
//                after each accepted row. Supports abort and done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module row_scan_scheduler
    import row_sched_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned PTR_BITS = $clog2(NUM_ROWS),
    parameter int unsigned DWELL_W  = DWELL_W_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           reset,
    row_scan_scheduler_if.master bus
);

    typedef logic [PTR_BITS:0] cnt_t;

    localparam cnt_t               c_cnt_one   = cnt_t'(1);
    localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

    sched_state_t        r_state;
    sched_state_t        w_state_next;
    cnt_t                r_remaining;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    cnt_t                w_clamped;
    logic                w_last;
    logic                w_load;
    logic                w_advance;
    logic [PTR_BITS-1:0] w_ptr;

    assign w_clamped = cnt_t'(clamp_rows(32'(bus.cfg_num_rows), NUM_ROWS));
    assign w_last    = (r_state == ST_ISSUE) && (r_remaining == c_cnt_one);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the pointer load/advance strobes.
    // Abort beats a simultaneous handshake, so no advance is issued with it.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = (w_clamped == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else if (bus.row_ready) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                        if (r_dwell != '0) begin
                            w_state_next = ST_DWELL;
                        end
                    end
                end
            end
            ST_DWELL: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_dwell_cnt <= c_dwell_one) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Scan bookkeeping: remaining-row count and dwell gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_load) begin
                r_remaining <= w_clamped;
                r_dwell     <= bus.cfg_dwell;
            end else if (w_advance) begin
                r_remaining <= r_remaining - c_cnt_one;
            end

            if (w_advance) begin
                r_dwell_cnt <= r_dwell;
            end else if ((r_state == ST_DWELL) && (r_dwell_cnt != '0)) begin
                r_dwell_cnt <= r_dwell_cnt - c_dwell_one;
            end
        end
    end

    row_ptr_wrap_counter #(
        .NUM_ROWS (NUM_ROWS),
        .PTR_BITS (PTR_BITS)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (bus.cfg_first_row),
        .incr       (w_advance),
        .count      (w_ptr)
    );

    assign bus.row_valid = (r_state == ST_ISSUE);
    assign bus.row_ptr   = w_ptr;
    assign bus.row_last  = w_last;
    assign bus.busy      = (r_state != ST_IDLE);
    // An abort landing on the completion cycle suppresses the done pulse.
    assign bus.done      = (r_state == ST_DONE) && !bus.abort;

endmodule
`default_nettype wire

// File: tb/tb_row_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_scan_scheduler
//  Description : Self-checking bench for row_scan_scheduler. Two instances
//                (8 rows and 6 rows) share one stimulus stream; each is
//                compared every cycle against a scan-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_row_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       row_ready;
    logic [2:0] cfg_first_row;
    logic [3:0] cfg_num_rows;
    logic [7:0] cfg_dwell;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    row_scan_scheduler_if #(.NUM_ROWS(8)) if8 ();
    row_scan_scheduler_if #(.NUM_ROWS(6)) if6 ();

    assign if8.start = start;          assign if6.start = start;
    assign if8.abort = abort;          assign if6.abort = abort;
    assign if8.row_ready = row_ready;  assign if6.row_ready = row_ready;
    assign if8.cfg_first_row = cfg_first_row;  assign if6.cfg_first_row = cfg_first_row;
    assign if8.cfg_num_rows  = cfg_num_rows;   assign if6.cfg_num_rows  = cfg_num_rows;
    assign if8.cfg_dwell     = cfg_dwell;      assign if6.cfg_dwell     = cfg_dwell;

    row_scan_scheduler #(.NUM_ROWS(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));
    row_scan_scheduler #(.NUM_ROWS(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));

    logic       obs_valid [2];
    logic       obs_last  [2];
    logic       obs_busy  [2];
    logic       obs_done  [2];
    logic [2:0] obs_ptr   [2];

    assign obs_valid[0] = if8.row_valid;  assign obs_valid[1] = if6.row_valid;
    assign obs_last[0]  = if8.row_last;   assign obs_last[1]  = if6.row_last;
    assign obs_busy[0]  = if8.busy;       assign obs_busy[1]  = if6.busy;
    assign obs_done[0]  = if8.done;       assign obs_done[1]  = if6.done;
    assign obs_ptr[0]   = if8.row_ptr;    assign obs_ptr[1]   = if6.row_ptr;

    // Reference model: a scan is "rows first, first+1, ... mod N, total of
    // min(num, N)", with a gap of dwell idle cycles after each non-final row.
    int unsigned m_n      [2] = '{8, 6};
    bit          m_active [2] = '{0, 0};
    bit          m_donep  [2] = '{0, 0};
    bit          m_ptr_rst[2] = '{1, 1};
    int unsigned m_first  [2] = '{0, 0};
    int unsigned m_issued [2] = '{0, 0};
    int unsigned m_total  [2] = '{0, 0};
    int unsigned m_gap    [2] = '{0, 0};
    int unsigned m_dwell  [2] = '{0, 0};

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic compare_outputs(input int k);
        bit          ev;
        int unsigned n;
        n  = m_n[k];
        ev = m_active[k] && !m_donep[k] && (m_gap[k] == 0);
        check($sformatf("n%0d_row_valid", n), obs_valid[k], ev);
        check($sformatf("n%0d_busy", n), obs_busy[k], m_active[k]);
        check($sformatf("n%0d_done", n), obs_done[k], m_active[k] && m_donep[k] && !abort);
        check($sformatf("n%0d_row_last", n), obs_last[k], ev && (m_issued[k] + 1 == m_total[k]));
        if (ev)
            check($sformatf("n%0d_row_ptr", n), obs_ptr[k], (m_first[k] + m_issued[k]) % n);
        else if (m_ptr_rst[k])
            check($sformatf("n%0d_row_ptr_reset", n), obs_ptr[k], 0);
    endtask

    task automatic model_update(input int k);
        if (reset) begin
            m_active[k]  = 0;
            m_donep[k]   = 0;
            m_gap[k]     = 0;
            m_ptr_rst[k] = 1;
        end else if (!m_active[k]) begin
            if (start) begin
                m_active[k]  = 1;
                m_first[k]   = cfg_first_row;
                m_total[k]   = (cfg_num_rows > m_n[k]) ? m_n[k] : cfg_num_rows;
                m_issued[k]  = 0;
                m_dwell[k]   = cfg_dwell;
                m_gap[k]     = 0;
                m_donep[k]   = (m_total[k] == 0);
                m_ptr_rst[k] = 0;
            end
        end else if (abort) begin
            m_active[k] = 0;
            m_donep[k]  = 0;
        end else if (m_donep[k]) begin
            m_active[k] = 0;
            m_donep[k]  = 0;
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
        end else if (row_ready) begin
            m_issued[k]++;
            if (m_issued[k] == m_total[k]) m_donep[k] = 1;
            else                           m_gap[k]   = m_dwell[k];
        end
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) compare_outputs(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
    endtask

    task automatic launch(input int first, input int num, input int dwell);
        cfg_first_row = 3'(first);
        cfg_num_rows  = 4'(num);
        cfg_dwell     = 8'(dwell);
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_first_row = 3'($urandom_range(0, 5));
        cfg_num_rows  = 4'($urandom_range(0, 15));
        cfg_dwell     = 8'($urandom_range(0, 3));
    endtask

    // Run with ready high until both scans finish; returns rows accepted by dut8.
    task automatic drain(input int budget, output int rows8);
        rows8 = 0;
        row_ready = 1'b1;
        for (int i = 0; i < budget && (m_active[0] || m_active[1]); i++) begin
            @(negedge clk);
            if (if8.row_valid && row_ready) rows8++;
            for (int k = 0; k < 2; k++) compare_outputs(k);
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_update(k);
            #1;
        end
        check("drain_busy_n8", obs_busy[0], 0);
        check("drain_busy_n6", obs_busy[1], 0);
    endtask

    initial begin
        int rows;
        reset = 1'b1; start = 1'b0; abort = 1'b0; row_ready = 1'b1;
        cfg_first_row = '0; cfg_num_rows = '0; cfg_dwell = '0;
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;
        step();

        // Back-to-back rows, no dwell.
        launch(2, 4, 0);
        drain(100, rows);
        check("rows_first2_num4", rows, 4);

        // Wrapping scan with a two-cycle dwell.
        launch(4, 5, 2);
        drain(100, rows);
        check("rows_first4_num5", rows, 5);

        // Empty scan: only the done pulse.
        launch(1, 0, 3);
        drain(20, rows);
        check("rows_num0", rows, 0);

        // Downstream stall on the second row.
        launch(3, 3, 0);
        step();
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        drain(100, rows);
        check("rows_after_stall", rows, 2);

        // Abort together with the handshake on the second row, then relaunch.
        launch(0, 6, 0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("abort_busy_n8", obs_busy[0], 0);
        launch(5, 2, 1);
        drain(100, rows);
        check("rows_after_abort", rows, 2);

        // Reset while dwelling, then an over-long request.
        launch(1, 4, 3);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        launch(5, 15, 0);
        drain(100, rows);
        check("rows_clamped_n8", rows, 8);

        // Randomised traffic, including start while busy and config churn.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            start         = ($urandom_range(0, 3) == 0);
            abort         = ($urandom_range(0, 49) == 0);
            row_ready     = ($urandom_range(0, 3) != 0);
            cfg_first_row = 3'($urandom_range(0, 5));
            cfg_num_rows  = 4'($urandom_range(0, 15));
            cfg_dwell     = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            step();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        drain(200, rows);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
